// File: rtl/fpu_lzd_pipe.sv
// fpu_lzd_pipe: pipelined leading-zero / leading-one detector for the FMADD
// normaliser. The mantissa is conditioned (optional inversion, left-justified
// into a power-of-two width), then reduced by a tree of 2-bit cells and
// 2:1 merge nodes. Stage registers sit every LVLS_PER_STG levels and the root
// conversion feeds the final output register. Flow control is a global
// stall: every stage advances together when the output can move.
module fpu_lzd_pipe #(
    parameter int  W            = 24,
    parameter int  LVLS_PER_STG = 2,
    parameter int  TAG_W        = 4,
    localparam int CW           = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    // Padded tree width, number of tree levels and pipeline depth.
    localparam int PW  = 1 << $clog2(W);
    localparam int L   = $clog2(PW);
    localparam int LAT = (L + LVLS_PER_STG - 1) / LVLS_PER_STG;

    // ------------------------------------------------------------------
    // Global stall: the whole pipe moves only when the output slot is free
    // or is being drained this cycle.
    // ------------------------------------------------------------------
    logic advance;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // Pre-conditioning. Leading-one mode becomes leading-zero mode on the
    // inverted word. Zero padding goes below the data so it can never
    // produce a terminating bit ahead of real data.
    // ------------------------------------------------------------------
    logic [W-1:0]  mdata;
    logic [PW-1:0] pdata;

    // Invert for leading-one counting.
    always_comb begin
        mdata = in_mode ? ~in_data : in_data;
    end

    assign pdata = PW'(mdata) << (PW - W);

    // ------------------------------------------------------------------
    // Valid / tag shift register, one entry per pipeline register.
    // vld_pipe[LAT] is the output register. Bubbles travel as valid=0.
    // ------------------------------------------------------------------
    logic [LAT:1]            vld_pipe;
    logic [LAT:1][TAG_W-1:0] tag_pipe;

    // Shift valid bits and tags one stage forward on every advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid;
            tag_pipe[1] <= in_tag;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[LAT];
    assign out_tag   = tag_pipe[LAT];

    // ------------------------------------------------------------------
    // Reduction tree. Level k has PW>>(k+1) nodes, each with a val bit and a
    // (k+1)-bit pos giving the leading-zero count inside its 2^(k+1)-bit
    // span. cv/cp are the combinational node outputs, ov/op are what the
    // next level sees (registered at stage boundaries, wired otherwise).
    // The last level is never registered here: its register is the output
    // register after root conversion.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < L; k++) begin : lv
        localparam int N       = PW >> (k + 1);
        localparam bit STG_REG = (((k + 1) % LVLS_PER_STG) == 0) && (k < L - 1);

        logic [N-1:0]      cv;
        logic [N-1:0]      ov;
        logic [N-1:0][k:0] cp;
        logic [N-1:0][k:0] op;

        if (k == 0) begin : g_cell
            // 2-bit cells: pos is 0 when the upper bit of the pair is set.
            for (genvar j = 0; j < N; j++) begin : g_n
                assign cv[j] = pdata[2*j+1] | pdata[2*j];
                assign cp[j] = ~pdata[2*j+1];
            end
        end else begin : g_merge
            // Merge nodes: take the high half if it holds a one, otherwise
            // skip the whole high half and continue into the low half.
            for (genvar j = 0; j < N; j++) begin : g_n
                assign cv[j] = lv[k-1].ov[2*j+1] | lv[k-1].ov[2*j];
                assign cp[j] = lv[k-1].ov[2*j+1] ? {1'b0, lv[k-1].op[2*j+1]}
                                                 : {1'b1, lv[k-1].op[2*j]};
            end
        end

        if (STG_REG) begin : g_reg
            // Stage boundary: capture this level's nodes, hold on stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ov <= '0;
                    op <= '0;
                end else if (advance) begin
                    ov <= cv;
                    op <= cp;
                end
            end
        end else begin : g_wire
            assign ov = cv;
            assign op = cp;
        end
    end

    // ------------------------------------------------------------------
    // Root conversion. When the root is valid its pos is always below W
    // (padding sits under the data), so only the all-clear case saturates.
    // ------------------------------------------------------------------
    logic          root_val;
    logic [L-1:0]  root_pos;
    logic [CW-1:0] root_count;

    assign root_val = lv[L-1].ov[0];
    assign root_pos = lv[L-1].op[0];

    // Map the root node to a count, saturating to W when nothing was found.
    always_comb begin
        root_count = root_val ? CW'(root_pos) : CW'(W);
    end

    // Output register: loads with the rest of the pipe, holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            out_count <= root_count;
            out_zero  <= ~root_val;
        end
    end

endmodule

// File: tb/tb_fpu_lzd_pipe.sv
// Testbench for fpu_lzd_pipe: three instances (default, W=32/1 level per
// stage, W=11/4 levels per stage) checked against a bit-scanning reference
// with per-instance scoreboards, plus directed literal vectors.
`timescale 1ns/1ps
module tb_fpu_lzd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cnt;
        bit         zero;
        logic [3:0] tag;
    } exp_t;

    int checks = 0;
    int passed = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // ---------------- DUT A: defaults (W=24, LAT=3) ----------------
    logic        rst_a, iv_a, ir_a, im_a, ov_a, or_a, oz_a;
    logic [23:0] id_a;
    logic [3:0]  it_a, ot_a;
    logic [4:0]  oc_a;

    fpu_lzd_pipe dut_a (
        .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .in_mode(im_a), .in_tag(it_a), .out_valid(ov_a), .out_ready(or_a),
        .out_count(oc_a), .out_zero(oz_a), .out_tag(ot_a)
    );

    // ---------------- DUT B: W=32, one level per stage (LAT=5) ----------------
    logic        rst_bc, iv_b, ir_b, im_b, ov_b, or_b, oz_b;
    logic [31:0] id_b;
    logic [3:0]  it_b, ot_b;
    logic [5:0]  oc_b;

    fpu_lzd_pipe #(.W(32), .LVLS_PER_STG(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst_bc), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
        .in_mode(im_b), .in_tag(it_b), .out_valid(ov_b), .out_ready(or_b),
        .out_count(oc_b), .out_zero(oz_b), .out_tag(ot_b)
    );

    // ---------------- DUT C: W=11, four levels per stage (LAT=1) ----------------
    logic        iv_c, ir_c, im_c, ov_c, or_c, oz_c;
    logic [10:0] id_c;
    logic [3:0]  it_c, ot_c;
    logic [3:0]  oc_c;

    fpu_lzd_pipe #(.W(11), .LVLS_PER_STG(4), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst_bc), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
        .in_mode(im_c), .in_tag(it_c), .out_valid(ov_c), .out_ready(or_c),
        .out_count(oc_c), .out_zero(oz_c), .out_tag(ot_c)
    );

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Reference: scan from the MSB for the first bit that differs from mode.
    function automatic exp_t model(input logic [63:0] d, input int w, input bit m,
                                   input logic [3:0] t);
        exp_t e;
        int   n   = 0;
        bit   hit = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!hit) begin
                if (d[i] != m) hit = 1;
                else n++;
            end
        end
        e.cnt  = n;
        e.zero = (n == w);
        e.tag  = t;
        return e;
    endfunction

    // ---------------- scoreboards: check every valid output cycle ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_a) qa.delete();
        else begin
            if (ov_a) begin
                chk("a_result_expected", qa.size() != 0, qa.size(), 1);
                if (qa.size() != 0) begin
                    e = qa[0];
                    chk("a_count", oc_a == e.cnt, oc_a, e.cnt);
                    chk("a_zero", oz_a == e.zero, oz_a, e.zero);
                    chk("a_tag", ot_a == e.tag, ot_a, e.tag);
                    if (or_a) void'(qa.pop_front());
                end
            end
            if (iv_a && ir_a) qa.push_back(model({40'b0, id_a}, 24, im_a, it_a));
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_bc) qb.delete();
        else begin
            if (ov_b) begin
                chk("b_result_expected", qb.size() != 0, qb.size(), 1);
                if (qb.size() != 0) begin
                    e = qb[0];
                    chk("b_count", oc_b == e.cnt, oc_b, e.cnt);
                    chk("b_zero", oz_b == e.zero, oz_b, e.zero);
                    chk("b_tag", ot_b == e.tag, ot_b, e.tag);
                    if (or_b) void'(qb.pop_front());
                end
            end
            if (iv_b && ir_b) qb.push_back(model({32'b0, id_b}, 32, im_b, it_b));
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst_bc) qc.delete();
        else begin
            if (ov_c) begin
                chk("c_result_expected", qc.size() != 0, qc.size(), 1);
                if (qc.size() != 0) begin
                    e = qc[0];
                    chk("c_count", oc_c == e.cnt, oc_c, e.cnt);
                    chk("c_zero", oz_c == e.zero, oz_c, e.zero);
                    chk("c_tag", ot_c == e.tag, ot_c, e.tag);
                    if (or_c) void'(qc.pop_front());
                end
            end
            if (iv_c && ir_c) qc.push_back(model({53'b0, id_c}, 11, im_c, it_c));
        end
    end

    // ---------------- DUT A sequences ----------------
    task automatic a_directed(input string nm, input logic [23:0] d, input bit m,
                              input int ec, input bit ez, input logic [3:0] t);
        @(posedge clk); #1;
        iv_a = 1'b1; id_a = d; im_a = m; it_a = t;
        @(posedge clk); #1;
        iv_a = 1'b0;
        @(negedge clk);
        chk({nm, "_not_early"}, ov_a == 1'b0, ov_a, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, ov_a == 1'b1, ov_a, 1);
        chk({nm, "_count"}, oc_a == ec, oc_a, ec);
        chk({nm, "_zero"}, oz_a == ez, oz_a, ez);
        chk({nm, "_tag"}, ot_a == t, ot_a, t);
    endtask

    task automatic seq_a();
        int n;
        or_a = 1'b1;
        a_directed("a_msb",    24'h800000, 1'b0, 0,  1'b0, 4'd1);
        a_directed("a_lsb",    24'h000001, 1'b0, 23, 1'b0, 4'd2);
        a_directed("a_allz",   24'h000000, 1'b0, 24, 1'b1, 4'd3);
        a_directed("a_lo_ff0f", 24'hFF0F00, 1'b1, 8,  1'b0, 4'd4);
        a_directed("a_lo_allf", 24'hFFFFFF, 1'b1, 24, 1'b1, 4'd5);
        a_directed("a_lo_7f",  24'h7FFFFF, 1'b1, 0,  1'b0, 4'd6);

        // Streaming: 24 back-to-back beats, results on consecutive cycles.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    iv_a = 1'b1; im_a = 1'b0;
                    id_a = 24'h800000 >> i;
                    it_a = 4'(i % 16);
                    @(posedge clk); #1;
                end
                iv_a = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    chk("a_stream_valid", ov_a == 1'b1, ov_a, 1);
                    chk("a_stream_count", oc_a == i, oc_a, i);
                    chk("a_stream_tag", ot_a == 4'(i % 16), ot_a, i % 16);
                end
            end
        join

        // Backpressure: 6 beats, out_ready dropped for 4 cycles mid-stream.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int w;
                    iv_a = 1'b1; im_a = 1'b0;
                    id_a = 24'h800000 >> (i * 4);
                    it_a = 4'(i + 8);
                    w = 0;
                    @(negedge clk);
                    while (!ir_a && w < 50) begin @(negedge clk); w++; end
                    chk("a_bp_accept_timeout", w < 50, w, 0);
                    @(posedge clk); #1;
                end
                iv_a = 1'b0;
            end
            begin
                int         w;
                logic [4:0] hc;
                logic       hz;
                logic [3:0] ht;
                w = 0;
                @(negedge clk);
                while (!ov_a && w < 50) begin @(negedge clk); w++; end
                chk("a_bp_first_out_timeout", w < 50, w, 0);
                @(posedge clk); #1;
                or_a = 1'b0;
                @(negedge clk);
                hc = oc_a; hz = oz_a; ht = ot_a;
                chk("a_bp_stall_valid", ov_a == 1'b1, ov_a, 1);
                chk("a_bp_in_ready_low", ir_a == 1'b0, ir_a, 0);
                for (int k = 1; k < 4; k++) begin
                    @(negedge clk);
                    chk("a_bp_hold_valid", ov_a == 1'b1, ov_a, 1);
                    chk("a_bp_hold_count", oc_a == hc, oc_a, hc);
                    chk("a_bp_hold_zero", oz_a == hz, oz_a, hz);
                    chk("a_bp_hold_tag", ot_a == ht, ot_a, ht);
                    chk("a_bp_in_ready_low", ir_a == 1'b0, ir_a, 0);
                end
                @(posedge clk); #1;
                or_a = 1'b1;
            end
        join
        n = 0;
        while (qa.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("a_bp_all_delivered", qa.size() == 0, qa.size(), 0);

        // Reset with three beats in flight: nothing from them may surface.
        @(posedge clk); #1;
        or_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv_a = 1'b1; im_a = 1'b0; id_a = 24'h000F00; it_a = 4'(12 + i);
            @(posedge clk); #1;
        end
        iv_a = 1'b0;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        or_a = 1'b1;
        @(negedge clk);
        chk("a_rst_out_valid", ov_a == 1'b0, ov_a, 0);
        chk("a_rst_in_ready", ir_a == 1'b1, ir_a, 1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov_a) n++;
        end
        chk("a_rst_no_stale", n == 0, n, 0);
    endtask

    // ---------------- DUT B sequence ----------------
    task automatic seq_b();
        logic [31:0] bv[2] = '{32'h00010000, 32'h00000000};
        int          be[2] = '{15, 32};
        bit          bz[2] = '{1'b0, 1'b1};
        logic [31:0] x;
        or_b = 1'b1;
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            iv_b = 1'b1; id_b = bv[v]; im_b = 1'b0; it_b = 4'(v + 3);
            @(posedge clk); #1;
            iv_b = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("b_lit_not_early", ov_b == 1'b0, ov_b, 0);
                @(posedge clk);
            end
            @(negedge clk);
            chk("b_lit_valid", ov_b == 1'b1, ov_b, 1);
            chk("b_lit_count", oc_b == be[v], oc_b, be[v]);
            chk("b_lit_zero", oz_b == bz[v], oz_b, bz[v]);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 300; c++) begin
            iv_b = ($urandom_range(0, 3) != 0);
            x    = $urandom;
            x    = x >> $urandom_range(0, 32);
            im_b = 1'($urandom_range(0, 1));
            id_b = im_b ? ~x : x;
            it_b = 4'($urandom_range(0, 15));
            or_b = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        iv_b = 1'b0;
        or_b = 1'b1;
    endtask

    // ---------------- DUT C sequence ----------------
    task automatic seq_c();
        logic [10:0] cv[3] = '{11'h000, 11'h100, 11'h3FF};
        bit          cm[3] = '{1'b0, 1'b0, 1'b1};
        int          ce[3] = '{11, 2, 0};
        bit          cz[3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] x;
        logic [10:0] y;
        or_c = 1'b1;
        for (int v = 0; v < 3; v++) begin
            @(posedge clk); #1;
            iv_c = 1'b1; id_c = cv[v]; im_c = cm[v]; it_c = 4'(v + 5);
            @(posedge clk); #1;
            iv_c = 1'b0;
            @(negedge clk);
            chk("c_lit_valid", ov_c == 1'b1, ov_c, 1);
            chk("c_lit_count", oc_c == ce[v], oc_c, ce[v]);
            chk("c_lit_zero", oz_c == cz[v], oz_c, cz[v]);
            chk("c_lit_tag", ot_c == 4'(v + 5), ot_c, v + 5);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 300; c++) begin
            iv_c = ($urandom_range(0, 3) != 0);
            x    = $urandom;
            y    = x[10:0];
            y    = y >> $urandom_range(0, 11);
            im_c = 1'($urandom_range(0, 1));
            id_c = im_c ? ~y : y;
            it_c = 4'($urandom_range(0, 15));
            or_c = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        iv_c = 1'b0;
        or_c = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst_a = 1'b1; rst_bc = 1'b1;
        iv_a = 1'b0; id_a = '0; im_a = 1'b0; it_a = '0; or_a = 1'b1;
        iv_b = 1'b0; id_b = '0; im_b = 1'b0; it_b = '0; or_b = 1'b1;
        iv_c = 1'b0; id_c = '0; im_c = 1'b0; it_c = '0; or_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_bc = 1'b0;
        @(negedge clk);
        chk("a_reset_out_valid", ov_a == 1'b0, ov_a, 0);
        chk("a_reset_out_count", oc_a == 5'd0, oc_a, 0);
        chk("a_reset_out_zero", oz_a == 1'b0, oz_a, 0);
        chk("a_reset_out_tag", ot_a == 4'd0, ot_a, 0);
        chk("a_reset_in_ready", ir_a == 1'b1, ir_a, 1);
        chk("b_reset_out_valid", ov_b == 1'b0, ov_b, 0);
        chk("c_reset_out_valid", ov_c == 1'b0, ov_c, 0);
        chk("c_reset_out_count", oc_c == 4'd0, oc_c, 0);

        fork
            seq_a();
            seq_b();
            seq_c();
        join

        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", qa.size() == 0, qa.size(), 0);
        chk("b_drain", qb.size() == 0, qb.size(), 0);
        chk("c_drain", qc.size() == 0, qc.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
